ccip_mmio_csr_responder: RTL and testbench
==========================================

Name: ccip_mmio_csr_responder

Overview:
- MMIO target on the AFU side of the CCI-P link, clocked in the AFU domain beside the AFU's data path.
- Accepts host MMIO read/write requests decoded from the c0 Rx channel.
- Holds the AFU's DFH, AFU ID, control, status, error and scratch CSRs.
- Returns MMIO read responses on the c2 Tx channel with the originating tid, at fixed latency, with no backpressure.

Parameters:
- DFH_VALUE, 64'h1000_0000_0000_1000: read-only value at byte offset 0x000.
- AFU_ID_L, 64'h0: read-only value at 0x008.
- AFU_ID_H, 64'h0: read-only value at 0x010.
- NUM_SCRATCH, 4: number of 64-bit RW scratch registers at 0x040 + 8*i; legal range 1..16.
- CTRL_RESET, 64'h0: reset value of the CTRL register.

Ports:
- Clk_400 in 1: sole clock. Rising edge.
- SoftReset_n in 1: asynchronous assert, active-low reset. Deassertion is synchronised externally.
- rx_mmio_rd_valid in 1: MMIO read request strobe, one cycle.
- rx_mmio_wr_valid in 1: MMIO write request strobe, one cycle.
- rx_mmio_addr in 16: dword address. addr[0] selects the upper dword; addr[15:1] is the qword index.
- rx_mmio_len in 2: 0 = 4B, 1 = 8B. Values 2 and 3 are illegal.
- rx_mmio_tid in 9: transaction id, meaningful for reads only.
- rx_mmio_data in 64: write data. For 4B writes, only bits [31:0] are valid.
- tx_mmio_rsp_valid out 1: read response strobe.
- tx_mmio_rsp_tid out 9: echoed tid.
- tx_mmio_rsp_data out 64: read data.
- ctrl_out out 64: current CTRL register value.
- err_out out 3: current ERR register value.

Behaviour:
- Reset (SoftReset_n = 0, asynchronous) clears the following:
  - tx_mmio_rsp_valid = 0.
  - tx_mmio_rsp_tid = 0 and tx_mmio_rsp_data = 0.
  - CTRL = CTRL_RESET, so ctrl_out = CTRL_RESET.
  - ERR = 0, CYCLE = 0, all scratch registers = 0.
  - Both pipeline stages are flushed. In-flight reads are dropped and never answered.
- Register map (byte offset = 4*addr):
  - 0x000: DFH, RO.
  - 0x008: AFU_ID_L, RO.
  - 0x010: AFU_ID_H, RO.
  - 0x018: reserved, RO, reads 0.
  - 0x020: CTRL, RW.
  - 0x028: CYCLE, RO. 64-bit free-running counter, increments every cycle out of reset, wraps 2^64-1 -> 0.
  - 0x030: ERR, W1C.
    - bit0: 8B access with addr[0] = 1.
    - bit1: access to an unmapped offset.
    - bit2: rd_valid and wr_valid asserted in the same cycle, or len >= 2.
  - 0x040 + 8*i: SCRATCH i, RW, for i < NUM_SCRATCH.
- Writes are committed at the end of the request cycle N and are visible to any read presented in cycle N+1 or later.
  - 8B write replaces all 64 bits.
  - 4B write replaces only the addressed dword (addr[0] = 0: bits [31:0]; addr[0] = 1: bits [63:32]). The other dword is preserved.
  - Writes to RO offsets are ignored and do not set ERR.
  - Writes to unmapped offsets are ignored and set ERR bit1.
  - ERR write: each 1 in the written data clears the corresponding bit. If a new error event occurs in the same cycle, the set wins.
- Reads use a fixed 2-stage pipeline. A request in cycle N produces tx_mmio_rsp_valid = 1 in cycle N+2 for exactly one cycle, with the same tid.
  - A new read may arrive every cycle, so the pipeline is fully pipelined with no stalls.
  - Register values are sampled in stage 2 (cycle N+1).
  - 8B read returns the full qword.
  - 4B read returns the selected dword replicated in both halves of tx_mmio_rsp_data.
  - Unmapped read returns 0 and sets ERR bit1.
  - Misaligned 8B read (addr[0] = 1) returns the qword at addr[15:1] and sets ERR bit0.
  - CYCLE read returns the counter value as of cycle N+1.
- Simultaneous rd_valid and wr_valid: the write is performed, the read is dropped (no response), and ERR bit2 is set.
- len >= 2:
  - A write is ignored.
  - A read is answered with data 0.
  - ERR bit2 is set in both cases.
- Outputs are registered with no combinational Rx -> Tx path. err_out and ctrl_out reflect register state.

Test Plan:
- Reset then 8B reads of 0x000, 0x008, 0x028 at consecutive cycles:
  - Three responses at N+2, N+3, N+4 carrying tids 1, 2, 3.
  - Data: DFH_VALUE, AFU_ID_L, then a CYCLE value that increases.
- 8B write 0x1122334455667788 to SCRATCH0 (addr 0x10) in cycle N, then 8B read at N+1: response data 0x1122334455667788.
- 4B write 0xDEADBEEF to addr 0x11 (upper dword of SCRATCH0), then 4B read of addr 0x10:
  - Returns 0x5566778855667788.
  - An 8B read then returns 0xDEADBEEF55667788.
- Read unmapped byte offset 0x200:
  - Data 0, err_out = 3'b010.
  - ERR write 0x2 in the same cycle as a new unmapped access: ERR bit1 stays 1.
  - A later ERR write 0x2 alone: err_out = 0.
- rd_valid and wr_valid both high to CTRL with data 0x5: ctrl_out = 0x5 next cycle, no response, err_out bit2 = 1.
- Reads issued in cycles N and N+1, SoftReset_n low in cycle N+1:
  - No tx_mmio_rsp_valid ever appears for either read.
  - ctrl_out = CTRL_RESET and CYCLE restarts from 0.

Source files
------------

// File: rtl/ccip_mmio_csr_responder_if.sv
// CCI-P MMIO request/response bundle between the c0 Rx decoder
// and the AFU CSR responder.
interface ccip_mmio_csr_responder_if;
  logic        rx_mmio_rd_valid;
  logic        rx_mmio_wr_valid;
  logic [15:0] rx_mmio_addr;
  logic [1:0]  rx_mmio_len;
  logic [8:0]  rx_mmio_tid;
  logic [63:0] rx_mmio_data;
  logic        tx_mmio_rsp_valid;
  logic [8:0]  tx_mmio_rsp_tid;
  logic [63:0] tx_mmio_rsp_data;

  modport master (
    output rx_mmio_rd_valid, rx_mmio_wr_valid,
    output rx_mmio_addr, rx_mmio_len,
    output rx_mmio_tid, rx_mmio_data,
    input  tx_mmio_rsp_valid, tx_mmio_rsp_tid,
    input  tx_mmio_rsp_data
  );

  modport slave (
    input  rx_mmio_rd_valid, rx_mmio_wr_valid,
    input  rx_mmio_addr, rx_mmio_len,
    input  rx_mmio_tid, rx_mmio_data,
    output tx_mmio_rsp_valid, tx_mmio_rsp_tid,
    output tx_mmio_rsp_data
  );
endinterface

// File: rtl/ccip_mmio_csr_responder.sv
// AFU-side MMIO CSR target: DFH/ID/CTRL/CYCLE/ERR/scratch,
// two-stage fixed-latency read path, single-cycle writes.
module ccip_mmio_csr_responder #(
  parameter logic [63:0] DFH_VALUE   = 64'h1000_0000_0000_1000,
  parameter logic [63:0] AFU_ID_L    = 64'h0,
  parameter logic [63:0] AFU_ID_H    = 64'h0,
  parameter int          NUM_SCRATCH = 4,
  parameter logic [63:0] CTRL_RESET  = 64'h0
) (
  input  logic                     Clk_400,
  input  logic                     SoftReset_n,
  ccip_mmio_csr_responder_if.slave mmio,
  output logic [63:0]              ctrl_out,
  output logic [2:0]               err_out
);

  localparam logic [14:0] QCTRL = 15'd4;
  localparam logic [14:0] QCYC  = 15'd5;
  localparam logic [14:0] QERR  = 15'd6;
  localparam logic [14:0] QSCR  = 15'd8;

  logic [63:0] ctrlQ;
  logic [63:0] cycleQ;
  logic [2:0]  errQ;
  logic [63:0] scrQ [NUM_SCRATCH];

  logic        s1Valid;
  logic [15:0] s1Addr;
  logic [1:0]  s1Len;
  logic [8:0]  s1Tid;

  logic [14:0] wq;
  logic [14:0] rq;
  logic        wrOk;
  logic        rdAcc;
  logic [2:0]  wrSet;
  logic [2:0]  rdSet;
  logic [2:0]  errClr;
  logic [63:0] qword;
  logic [63:0] rdData;

  function automatic logic isMapped(input logic [14:0] q);
    return (q < 15'd7) ||
           (q >= QSCR && q < QSCR + 15'(NUM_SCRATCH));
  endfunction

  function automatic logic [63:0] merge(
    input logic [63:0] old,
    input logic [63:0] d,
    input logic        len8,
    input logic        hi
  );
    if (len8) return d;
    return hi ? {d[31:0], old[31:0]}
              : {old[63:32], d[31:0]};
  endfunction

  // Request-cycle decode: write side effects and error events
  always_comb begin
    wq     = mmio.rx_mmio_addr[15:1];
    wrOk   = mmio.rx_mmio_wr_valid && !mmio.rx_mmio_len[1];
    rdAcc  = mmio.rx_mmio_rd_valid && !mmio.rx_mmio_wr_valid;
    wrSet  = '0;
    errClr = '0;
    if (mmio.rx_mmio_wr_valid) begin
      wrSet[2] = mmio.rx_mmio_len[1] | mmio.rx_mmio_rd_valid;
      wrSet[1] = !mmio.rx_mmio_len[1] && !isMapped(wq);
      wrSet[0] = !mmio.rx_mmio_len[1] && mmio.rx_mmio_len[0]
                 && mmio.rx_mmio_addr[0];
    end
    if (wrOk && wq == QERR &&
        (mmio.rx_mmio_len[0] || !mmio.rx_mmio_addr[0]))
      errClr = mmio.rx_mmio_data[2:0];
  end

  // Stage 2: sample the register file for the read in flight
  always_comb begin
    rq = s1Addr[15:1];
    case (rq)
      15'd0:   qword = DFH_VALUE;
      15'd1:   qword = AFU_ID_L;
      15'd2:   qword = AFU_ID_H;
      QCTRL:   qword = ctrlQ;
      QCYC:    qword = cycleQ;
      QERR:    qword = {61'b0, errQ};
      default: qword = '0;
    endcase
    for (int i = 0; i < NUM_SCRATCH; i++)
      if (rq == QSCR + 15'(i)) qword = scrQ[i];
    if (s1Len[1])
      rdData = '0;
    else if (s1Len[0])
      rdData = qword;
    else if (s1Addr[0])
      rdData = {2{qword[63:32]}};
    else
      rdData = {2{qword[31:0]}};
    rdSet = '0;
    if (s1Valid) begin
      rdSet[2] = s1Len[1];
      rdSet[1] = !s1Len[1] && !isMapped(rq);
      rdSet[0] = !s1Len[1] && s1Len[0] && s1Addr[0];
    end
  end

  always_ff @(posedge Clk_400 or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      ctrlQ                  <= CTRL_RESET;
      cycleQ                 <= '0;
      errQ                   <= '0;
      for (int i = 0; i < NUM_SCRATCH; i++)
        scrQ[i]              <= '0;
      s1Valid                <= 1'b0;
      s1Addr                 <= '0;
      s1Len                  <= '0;
      s1Tid                  <= '0;
      mmio.tx_mmio_rsp_valid <= 1'b0;
      mmio.tx_mmio_rsp_tid   <= '0;
      mmio.tx_mmio_rsp_data  <= '0;
    end else begin
      cycleQ <= cycleQ + 64'd1;
      // new error events win over a same-cycle W1C clear
      errQ   <= (errQ & ~errClr) | wrSet | rdSet;
      if (wrOk && wq == QCTRL)
        ctrlQ <= merge(ctrlQ, mmio.rx_mmio_data,
                       mmio.rx_mmio_len[0],
                       mmio.rx_mmio_addr[0]);
      for (int i = 0; i < NUM_SCRATCH; i++)
        if (wrOk && wq == QSCR + 15'(i))
          scrQ[i] <= merge(scrQ[i], mmio.rx_mmio_data,
                           mmio.rx_mmio_len[0],
                           mmio.rx_mmio_addr[0]);
      s1Valid                <= rdAcc;
      s1Addr                 <= mmio.rx_mmio_addr;
      s1Len                  <= mmio.rx_mmio_len;
      s1Tid                  <= mmio.rx_mmio_tid;
      mmio.tx_mmio_rsp_valid <= s1Valid;
      if (s1Valid) begin
        mmio.tx_mmio_rsp_tid  <= s1Tid;
        mmio.tx_mmio_rsp_data <= rdData;
      end
    end
  end

  assign ctrl_out = ctrlQ;
  assign err_out  = errQ;

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// Randomised + directed bench for the MMIO CSR responder against
// a register-map level reference model.
module tb_ccip_mmio_csr_responder;

  localparam logic [63:0] DFH  = 64'h1000_0000_0000_1000;
  localparam logic [63:0] IDL  = 64'hA5A5_0001_0000_00FF;
  localparam logic [63:0] IDH  = 64'h0123_4567_89AB_CDEF;
  localparam int          NS   = 4;
  localparam logic [63:0] CRST = 64'h0000_0000_0000_00C0;

  logic        clk;
  logic        SoftReset_n;
  logic [63:0] ctrl_out;
  logic [2:0]  err_out;

  ccip_mmio_csr_responder_if mmio ();

  ccip_mmio_csr_responder #(
    .DFH_VALUE  (DFH),
    .AFU_ID_L   (IDL),
    .AFU_ID_H   (IDH),
    .NUM_SCRATCH(NS),
    .CTRL_RESET (CRST)
  ) dut (
    .Clk_400    (clk),
    .SoftReset_n(SoftReset_n),
    .mmio       (mmio),
    .ctrl_out   (ctrl_out),
    .err_out    (err_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int nVec = 0;
  int nErr = 0;

  logic [63:0] mCtrl;
  logic [63:0] mCyc;
  logic [63:0] mScr [NS];
  logic [2:0]  mErr;
  bit          pV;
  logic [15:0] pA;
  logic [1:0]  pL;
  logic [8:0]  pT;
  bit          eV;
  logic [8:0]  eT;
  logic [63:0] eD;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    nVec++;
    if (got !== exp) begin
      nErr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void mRead(input logic [15:0] a,
                                input logic [1:0] l,
                                output logic [63:0] d,
                                output logic [2:0] e);
    int off;
    logic [63:0] q;
    bit hit;
    off = int'(a[15:1]) * 8;
    e   = 3'b000;
    hit = 1;
    if (l >= 2) begin
      d = '0;
      e = 3'b100;
      return;
    end
    if (off == 0)       q = DFH;
    else if (off == 8)  q = IDL;
    else if (off == 16) q = IDH;
    else if (off == 24) q = '0;
    else if (off == 32) q = mCtrl;
    else if (off == 40) q = mCyc;
    else if (off == 48) q = {61'b0, mErr};
    else if (off >= 64 && off < 64 + 8 * NS) q = mScr[(off - 64) / 8];
    else begin
      q   = '0;
      hit = 0;
    end
    if (!hit) e[1] = 1'b1;
    if (l == 1 && a[0]) e[0] = 1'b1;
    if (l == 1)    d = q;
    else if (a[0]) d = {q[63:32], q[63:32]};
    else           d = {q[31:0], q[31:0]};
  endfunction

  function automatic logic [63:0] upd(input logic [63:0] old,
                                      input logic [15:0] a,
                                      input logic [1:0] l,
                                      input logic [63:0] d);
    if (l == 1) return d;
    if (a[0]) return {d[31:0], old[31:0]};
    return {old[63:32], d[31:0]};
  endfunction

  function automatic void mWrite(input logic [15:0] a,
                                 input logic [1:0] l,
                                 input logic [63:0] d,
                                 output logic [2:0] set,
                                 output logic [2:0] clr);
    int off;
    off = int'(a[15:1]) * 8;
    set = 3'b000;
    clr = 3'b000;
    if (l >= 2) begin
      set = 3'b100;
      return;
    end
    if (off == 32) mCtrl = upd(mCtrl, a, l, d);
    else if (off == 48) clr = (l == 1 || !a[0]) ? d[2:0] : 3'b000;
    else if (off >= 64 && off < 64 + 8 * NS)
      mScr[(off - 64) / 8] = upd(mScr[(off - 64) / 8], a, l, d);
    else if (off > 40) set[1] = 1'b1;
    if (l == 1 && a[0]) set[0] = 1'b1;
  endfunction

  task automatic cyc(input bit rd, input bit wr,
                     input logic [15:0] a, input logic [1:0] l,
                     input logic [8:0] t, input logic [63:0] d);
    logic [2:0]  rs;
    logic [2:0]  ws;
    logic [2:0]  wc;
    logic [63:0] rdD;
    mmio.rx_mmio_rd_valid = rd;
    mmio.rx_mmio_wr_valid = wr;
    mmio.rx_mmio_addr     = a;
    mmio.rx_mmio_len      = l;
    mmio.rx_mmio_tid      = t;
    mmio.rx_mmio_data     = d;
    @(posedge clk);
    rs = '0; ws = '0; wc = '0;
    eV = pV;
    if (pV) begin
      mRead(pA, pL, rdD, rs);
      eT = pT;
      eD = rdD;
    end
    if (wr) begin
      mWrite(a, l, d, ws, wc);
      if (rd) ws[2] = 1'b1;
    end
    pV = rd && !wr;
    pA = a; pL = l; pT = t;
    mErr = (mErr & ~wc) | ws | rs;
    mCyc = mCyc + 64'd1;
    #1;
    chk("rsp_valid", 64'(mmio.tx_mmio_rsp_valid), 64'(eV));
    if (eV) begin
      chk("rsp_tid", 64'(mmio.tx_mmio_rsp_tid), 64'(eT));
      chk("rsp_data", mmio.tx_mmio_rsp_data, eD);
    end
    chk("ctrl_out", ctrl_out, mCtrl);
    chk("err_out", 64'(err_out), 64'(mErr));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 16'h0, 2'd0, 9'd0, 64'h0);
  endtask

  task automatic doReset();
    SoftReset_n = 1'b0;
    mCtrl = CRST;
    mErr  = '0;
    mCyc  = '0;
    for (int i = 0; i < NS; i++) mScr[i] = '0;
    pV = 0;
    @(posedge clk);
    mmio.rx_mmio_rd_valid = 1'b0;
    mmio.rx_mmio_wr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", 64'(mmio.tx_mmio_rsp_valid), 64'd0);
    chk("rst_tid", 64'(mmio.tx_mmio_rsp_tid), 64'd0);
    chk("rst_data", mmio.tx_mmio_rsp_data, 64'd0);
    chk("rst_ctrl", ctrl_out, CRST);
    chk("rst_err", 64'(err_out), 64'd0);
    SoftReset_n = 1'b1;
  endtask

  initial begin
    SoftReset_n           = 1'b1;
    mmio.rx_mmio_rd_valid = 1'b0;
    mmio.rx_mmio_wr_valid = 1'b0;
    mmio.rx_mmio_addr     = '0;
    mmio.rx_mmio_len      = '0;
    mmio.rx_mmio_tid      = '0;
    mmio.rx_mmio_data     = '0;
    #1;
    doReset();

    // DFH, AFU_ID_L, CYCLE back to back
    cyc(1, 0, 16'h0000, 2'd1, 9'd1, 64'h0);
    cyc(1, 0, 16'h0002, 2'd1, 9'd2, 64'h0);
    cyc(1, 0, 16'h000A, 2'd1, 9'd3, 64'h0);
    idle(2);

    // scratch full and half writes, read-after-write
    cyc(0, 1, 16'h0010, 2'd1, 9'd0, 64'h1122334455667788);
    cyc(1, 0, 16'h0010, 2'd1, 9'd4, 64'h0);
    idle(2);
    cyc(0, 1, 16'h0011, 2'd0, 9'd0, 64'h0000_0000_DEAD_BEEF);
    cyc(1, 0, 16'h0010, 2'd0, 9'd5, 64'h0);
    cyc(1, 0, 16'h0010, 2'd1, 9'd6, 64'h0);
    idle(2);

    // unmapped read, clear racing a new error, then clean clear
    cyc(1, 0, 16'h0080, 2'd1, 9'd7, 64'h0);
    idle(2);
    cyc(1, 0, 16'h0080, 2'd1, 9'd8, 64'h0);
    cyc(0, 1, 16'h000C, 2'd1, 9'd0, 64'h2);
    idle(2);
    cyc(0, 1, 16'h000C, 2'd1, 9'd0, 64'h2);
    idle(1);

    // collision on CTRL, misaligned and illegal-length accesses
    cyc(1, 1, 16'h0008, 2'd1, 9'd9, 64'h5);
    idle(2);
    cyc(1, 0, 16'h0011, 2'd1, 9'd10, 64'h0);
    cyc(1, 0, 16'h0010, 2'd2, 9'd11, 64'h0);
    cyc(0, 1, 16'h0010, 2'd3, 9'd0, 64'hFFFF);
    cyc(0, 1, 16'h0009, 2'd0, 9'd0, 64'hAAAA_0000);
    cyc(1, 0, 16'h0008, 2'd1, 9'd12, 64'h0);
    idle(2);
    cyc(0, 1, 16'h000C, 2'd1, 9'd0, 64'h7);
    idle(1);

    // reads in flight when reset hits are dropped
    cyc(1, 0, 16'h0000, 2'd1, 9'd13, 64'h0);
    mmio.rx_mmio_rd_valid = 1'b1;
    mmio.rx_mmio_addr     = 16'h0002;
    mmio.rx_mmio_tid      = 9'd14;
    doReset();
    idle(3);
    cyc(1, 0, 16'h000A, 2'd1, 9'd15, 64'h0);
    idle(2);

    for (int n = 0; n < 400; n++) begin
      int          r;
      int          lr;
      bit          rd;
      bit          wr;
      logic [15:0] a;
      logic [1:0]  l;
      r  = int'($urandom_range(0, 9));
      rd = (r < 4) || (r == 8);
      wr = (r >= 4 && r <= 8);
      if ($urandom_range(0, 15) == 0)
        a = 16'h0100 | 16'($urandom_range(0, 1));
      else
        a = 16'($urandom_range(0, 31));
      lr = int'($urandom_range(0, 7));
      l  = (lr < 3) ? 2'd0 : (lr < 6) ? 2'd1 : 2'(lr - 4);
      cyc(rd, wr, a, l, 9'($urandom), {$urandom, $urandom});
    end
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
